// File: rtl/difftest_trigger_pkg.sv
// Shared definitions for the trigger-CSR difftest source: CSR addresses and
// the snapshot record carried through the alignment pipeline.
package difftest_trigger_pkg;

    localparam logic [11:0] ADDR_TSELECT = 12'h7A0;
    localparam logic [11:0] ADDR_TDATA1  = 12'h7A1;
    localparam logic [11:0] ADDR_TINFO   = 12'h7A4;

    typedef struct packed {
        logic [63:0] tselect;
        logic [63:0] tdata1;
        logic [63:0] tinfo;
        logic [7:0]  coreid;
    } trig_rec_t;

endpackage

// File: rtl/difftest_delay_pipe.sv
// Fixed-depth valid+payload shift register. A stage's payload only loads when
// the incoming valid is set, so the output payload holds between records.
module difftest_delay_pipe #(
    parameter int  DEPTH = 2,
    parameter type T     = logic
) (
    input  logic clock,
    input  logic reset,
    input  logic vld_i,
    input  T     pay_i,
    output logic vld_o,
    output T     pay_o
);

    logic [DEPTH:1] vld_q;
    T               pay_q [1:DEPTH];

    for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
        logic vld_in;
        T     pay_in;

        if (k == 1) begin : g_head
            assign vld_in = vld_i;
            assign pay_in = pay_i;
        end else begin : g_body
            assign vld_in = vld_q[k-1];
            assign pay_in = pay_q[k-1];
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                vld_q[k] <= 1'b0;
                pay_q[k] <= '0;
            end else begin
                vld_q[k] <= vld_in;
                if (vld_in) pay_q[k] <= pay_in;
            end
        end
    end

    assign vld_o = vld_q[DEPTH];
    assign pay_o = pay_q[DEPTH];

endmodule

// File: rtl/difftest_trigger_csr_source.sv
// Snoops CSR writes to shadow tselect/tdata1 and emits a delayed snapshot
// record whenever the visible trigger state changes (or on force/init).
module difftest_trigger_csr_source
    import difftest_trigger_pkg::*;
#(
    parameter int          NUM_TRIGGERS = 4,
    parameter int          DELAY        = 2,
    parameter logic [63:0] TINFO_VAL    = 64'h0000_0000_0000_0004,
    parameter logic [63:0] TDATA1_WMASK = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_wen,
    input  logic [11:0] io_waddr,
    input  logic [63:0] io_wdata,
    input  logic        io_force_sync,
    input  logic [7:0]  io_coreid_in,
    output logic        io_enable,
    output logic [63:0] io_tselect,
    output logic [63:0] io_tdata1,
    output logic [63:0] io_tinfo,
    output logic [7:0]  io_coreid,
    output logic [31:0] io_rec_count
);

    localparam int IDX_W = (NUM_TRIGGERS > 1) ? $clog2(NUM_TRIGGERS) : 1;

    logic [IDX_W-1:0] tsel_q, tsel_d;
    logic [63:0]      shadow_q [NUM_TRIGGERS];
    logic [63:0]      shadow_d [NUM_TRIGGERS];
    logic             init_pending_q;
    logic [31:0]      rec_count_q;

    logic      change;
    logic      rec_valid0;
    trig_rec_t rec0;
    trig_rec_t rec_out;

    always_comb begin
        tsel_d   = tsel_q;
        shadow_d = shadow_q;
        if (io_wen) begin
            case (io_waddr)
                // WARL: out-of-range selects are dropped, not truncated
                ADDR_TSELECT: if (io_wdata < 64'(NUM_TRIGGERS)) tsel_d = io_wdata[IDX_W-1:0];
                ADDR_TDATA1:  shadow_d[tsel_q] = (shadow_q[tsel_q] & ~TDATA1_WMASK)
                                               | (io_wdata & TDATA1_WMASK);
                ADDR_TINFO:   ;
                default:      ;
            endcase
        end
    end

    always_comb begin
        change     = (tsel_d != tsel_q) || (shadow_d[tsel_d] != shadow_q[tsel_q]);
        rec_valid0 = change || io_force_sync || init_pending_q;
        rec0       = '{tselect: 64'(tsel_d),
                       tdata1:  shadow_d[tsel_d],
                       tinfo:   TINFO_VAL,
                       coreid:  io_coreid_in};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tsel_q         <= '0;
            init_pending_q <= 1'b1;
            for (int i = 0; i < NUM_TRIGGERS; i++) shadow_q[i] <= '0;
        end else begin
            tsel_q         <= tsel_d;
            init_pending_q <= 1'b0;
            shadow_q       <= shadow_d;
        end
    end

    difftest_delay_pipe #(
        .DEPTH (DELAY),
        .T     (trig_rec_t)
    ) u_pipe (
        .clock (clock),
        .reset (reset),
        .vld_i (rec_valid0),
        .pay_i (rec0),
        .vld_o (io_enable),
        .pay_o (rec_out)
    );

    always_ff @(posedge clock) begin
        if (reset)          rec_count_q <= '0;
        else if (io_enable) rec_count_q <= rec_count_q + 32'd1;
    end

    assign io_tselect   = rec_out.tselect;
    assign io_tdata1    = rec_out.tdata1;
    assign io_tinfo     = rec_out.tinfo;
    assign io_coreid    = rec_out.coreid;
    assign io_rec_count = rec_count_q;

endmodule
